// File: rtl/spi_arb_pkg.sv
// Shared definitions for the two-requester SPI transaction arbiter:
// FSM encoding, default command codes and the default abort limit.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LAUNCH   = 2'd1,
    ST_WAIT_END = 2'd2,
    ST_DONE     = 2'd3
  } arb_state_t;

  localparam logic [7:0]  SPI_CMD_READ    = 8'h00;
  localparam logic [7:0]  SPI_CMD_WRITE   = 8'h69;
  localparam int unsigned SPI_TIMEOUT_DEF = 1024;

  function automatic logic is_legal_cmd(input logic [7:0] cmd,
                                        input logic [7:0] rd_code,
                                        input logic [7:0] wr_code);
    return (cmd == rd_code) || (cmd == wr_code);
  endfunction

endpackage

// File: rtl/spi_arb_timer.sv
// Per-phase watchdog: cleared when a watched state is entered, counts while
// enabled, and flags expiry on the cycle whose edge brings it to LIMIT-1.
module spi_arb_timer
  import spi_arb_pkg::*;
#(
  parameter int unsigned LIMIT = SPI_TIMEOUT_DEF
)(
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [15:0] r_cnt;
  logic [15:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + 16'd1;
  assign o_expired = i_en && (w_cnt_inc == 16'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_cnt_inc;
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter granting one of two requesters exclusive use of an SPI
// master, with per-phase timeout abort and illegal-command rejection.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = SPI_TIMEOUT_DEF,
  parameter logic [7:0]  CMD_READ       = SPI_CMD_READ,
  parameter logic [7:0]  CMD_WRITE      = SPI_CMD_WRITE
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [7:0]  req0_cmd,
  input  logic [23:0] req0_addr,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  output logic        req0_done,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic [7:0]  req1_cmd,
  input  logic [23:0] req1_addr,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        req1_done,
  output logic        req1_err,
  output logic        spi_enable,
  output logic [7:0]  spi_commands,
  output logic [23:0] spi_address,
  output logic [31:0] spi_data_out,
  input  logic        spi_cs,
  output logic        busy,
  output logic        grant_id
);

  arb_state_t  r_state, w_state_nxt;
  logic        r_rr, w_rr_nxt;
  logic        r_gid, w_gid_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_en, w_en_nxt;
  logic        r_err_flag, w_err_flag_nxt;
  logic [1:0]  r_rdy, w_rdy_nxt;
  logic [1:0]  r_done, w_done_nxt;
  logic [1:0]  r_err, w_err_nxt;
  logic [7:0]  r_cmd, w_cmd_nxt;
  logic [23:0] r_addr, w_addr_nxt;
  logic [31:0] r_data, w_data_nxt;

  logic        w_win;
  logic [7:0]  w_sel_cmd;
  logic [23:0] w_sel_addr;
  logic [31:0] w_sel_data;
  logic        w_tmr_clr, w_tmr_en, w_tmr_exp;

  // rr only breaks ties; a lone valid wins outright
  assign w_win      = (req0_valid && req1_valid) ? r_rr : req1_valid;
  assign w_sel_cmd  = w_win ? req1_cmd  : req0_cmd;
  assign w_sel_addr = w_win ? req1_addr : req0_addr;
  assign w_sel_data = w_win ? req1_data : req0_data;
  assign w_tmr_en   = (r_state == ST_LAUNCH) || (r_state == ST_WAIT_END);

  spi_arb_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_tmr_exp)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_nxt       = r_rr;
    w_gid_nxt      = r_gid;
    w_busy_nxt     = r_busy;
    w_en_nxt       = r_en;
    w_err_flag_nxt = r_err_flag;
    w_rdy_nxt      = '0;
    w_done_nxt     = '0;
    w_err_nxt      = '0;
    w_cmd_nxt      = r_cmd;
    w_addr_nxt     = r_addr;
    w_data_nxt     = r_data;
    w_tmr_clr      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          w_gid_nxt        = w_win;
          w_busy_nxt       = 1'b1;
          w_rdy_nxt[w_win] = 1'b1;
          if (is_legal_cmd(w_sel_cmd, CMD_READ, CMD_WRITE)) begin
            w_state_nxt    = ST_LAUNCH;
            w_en_nxt       = 1'b1;
            w_err_flag_nxt = 1'b0;
            w_tmr_clr      = 1'b1;
            w_cmd_nxt      = w_sel_cmd;
            w_addr_nxt     = w_sel_addr;
            w_data_nxt     = w_sel_data;
          end else begin
            w_state_nxt    = ST_DONE;
            w_err_flag_nxt = 1'b1;
          end
        end
      end
      ST_LAUNCH: begin
        if (w_tmr_exp) begin
          w_state_nxt    = ST_DONE;
          w_en_nxt       = 1'b0;
          w_err_flag_nxt = 1'b1;
        end else if (!spi_cs) begin
          w_state_nxt = ST_WAIT_END;
          w_en_nxt    = 1'b0;
          w_tmr_clr   = 1'b1;
        end
      end
      ST_WAIT_END: begin
        if (w_tmr_exp) begin
          w_state_nxt    = ST_DONE;
          w_err_flag_nxt = 1'b1;
        end else if (spi_cs) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done_nxt[r_gid] = 1'b1;
        w_err_nxt[r_gid]  = r_err_flag;
        w_busy_nxt        = 1'b0;
        w_rr_nxt          = ~r_gid;
        w_state_nxt       = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_rr       <= 1'b0;
      r_gid      <= 1'b0;
      r_busy     <= 1'b0;
      r_en       <= 1'b0;
      r_err_flag <= 1'b0;
      r_rdy      <= '0;
      r_done     <= '0;
      r_err      <= '0;
      r_cmd      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr       <= w_rr_nxt;
      r_gid      <= w_gid_nxt;
      r_busy     <= w_busy_nxt;
      r_en       <= w_en_nxt;
      r_err_flag <= w_err_flag_nxt;
      r_rdy      <= w_rdy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_cmd      <= w_cmd_nxt;
      r_addr     <= w_addr_nxt;
      r_data     <= w_data_nxt;
    end
  end

  assign req0_ready   = r_rdy[0];
  assign req1_ready   = r_rdy[1];
  assign req0_done    = r_done[0];
  assign req1_done    = r_done[1];
  assign req0_err     = r_err[0];
  assign req1_err     = r_err[1];
  assign spi_enable   = r_en;
  assign spi_commands = r_cmd;
  assign spi_address  = r_addr;
  assign spi_data_out = r_data;
  assign busy         = r_busy;
  assign grant_id     = r_gid;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Scoreboard bench for spi_req_arbiter: directed transactions push expected
// ready/done events; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_spi_req_arbiter;

  localparam int LEGAL_LAT = 73;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v0 = 1'b0, v1 = 1'b0;
  logic [7:0]  c0 = '0, c1 = '0;
  logic [23:0] a0 = '0, a1 = '0;
  logic [31:0] d0 = '0, d1 = '0;
  logic        cs = 1'b1;
  logic        rdy0, rdy1, dn0, dn1, er0, er1, en, busy, gid;
  logic [7:0]  scmd;
  logic [23:0] saddr;
  logic [31:0] sdata;

  logic        tv = 1'b0;
  logic [7:0]  tc = '0;
  logic [23:0] ta = '0;
  logic [31:0] td = '0;
  logic        t_cs = 1'b1, t_off = 1'b0;
  logic [7:0]  t_c1 = '0;
  logic [23:0] t_a1 = '0;
  logic [31:0] t_d1 = '0;
  logic        t_rdy0, t_rdy1, t_dn0, t_dn1, t_er0, t_er1, t_en, t_busy, t_gid;
  logic [7:0]  t_scmd;
  logic [23:0] t_saddr;
  logic [31:0] t_sdata;

  spi_req_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_cmd(c0), .req0_addr(a0), .req0_data(d0),
    .req0_ready(rdy0), .req0_done(dn0), .req0_err(er0),
    .req1_valid(v1), .req1_cmd(c1), .req1_addr(a1), .req1_data(d1),
    .req1_ready(rdy1), .req1_done(dn1), .req1_err(er1),
    .spi_enable(en), .spi_commands(scmd), .spi_address(saddr), .spi_data_out(sdata),
    .spi_cs(cs), .busy(busy), .grant_id(gid)
  );

  spi_req_arbiter #(.TIMEOUT_CYCLES(16)) dut_t (
    .clk(clk), .rst(rst),
    .req0_valid(tv), .req0_cmd(tc), .req0_addr(ta), .req0_data(td),
    .req0_ready(t_rdy0), .req0_done(t_dn0), .req0_err(t_er0),
    .req1_valid(t_off), .req1_cmd(t_c1), .req1_addr(t_a1), .req1_data(t_d1),
    .req1_ready(t_rdy1), .req1_done(t_dn1), .req1_err(t_er1),
    .spi_enable(t_en), .spi_commands(t_scmd), .spi_address(t_saddr), .spi_data_out(t_sdata),
    .spi_cs(t_cs), .busy(t_busy), .grant_id(t_gid)
  );

  typedef struct {
    bit          is_done;
    bit          id;
    bit          err;
    bit          chk_f;
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [31:0] data;
    int          lat;
    int          en_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rdy_cyc = 0;
  int   en_cnt = 0;
  int   m_phase = 0;
  int   m_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SPI master model: cs falls on the 2nd enable cycle, rises 70 cycles later
  always @(negedge clk) begin
    if (!rst) begin
      cs = 1'b1; m_phase = 0; m_cnt = 0;
    end else if (m_phase == 0) begin
      if (en) begin
        m_cnt++;
        if (m_cnt == 2) begin cs = 1'b0; m_phase = 1; m_cnt = 0; end
      end else m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == 70) begin cs = 1'b1; m_phase = 0; m_cnt = 0; end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (rdy0 || rdy1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready: got rdy=%b%b expected none", rdy1, rdy0);
        end else begin
          m_e = sb.pop_front();
          chk("event_kind_ready", 64'(m_e.is_done), 64'(0));
          chk("ready_id", 64'(rdy1), 64'(m_e.id));
          chk("grant_id", 64'(gid), 64'(m_e.id));
          chk("busy_at_ready", 64'(busy), 64'(1));
          if (m_e.chk_f) begin
            chk("spi_commands", 64'(scmd), 64'(m_e.cmd));
            chk("spi_address", 64'(saddr), 64'(m_e.addr));
            chk("spi_data_out", 64'(sdata), 64'(m_e.data));
          end
          rdy_cyc = cyc;
          en_cnt = 0;
        end
      end
      if (en) en_cnt++;
      if (dn0 || dn1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=%b%b expected none", dn1, dn0);
        end else begin
          m_e = sb.pop_front();
          chk("event_kind_done", 64'(m_e.is_done), 64'(1));
          chk("done_id", 64'(dn1), 64'(m_e.id));
          chk("done_err", 64'(dn1 ? er1 : er0), 64'(m_e.err));
          chk("done_latency", 64'(cyc - rdy_cyc), 64'(m_e.lat));
          chk("enable_cycles", 64'(en_cnt), 64'(m_e.en_cyc));
          chk("busy_at_done", 64'(busy), 64'(0));
        end
      end
    end
  end

  task automatic push_txn(input bit id, input logic [7:0] cmd, input logic [23:0] addr,
                          input logic [31:0] data, input bit with_done);
    bit legal;
    legal = (cmd == 8'h00) || (cmd == 8'h69);
    sb.push_back('{0, id, 0, legal, cmd, addr, data, 0, 0});
    if (with_done)
      sb.push_back('{1, id, !legal, 0, cmd, addr, data, legal ? LEGAL_LAT : 1, legal ? 2 : 0});
  endtask

  task automatic raise(input bit id, input logic [7:0] cmd, input logic [23:0] addr,
                       input logic [31:0] data);
    if (id) begin v1 = 1'b1; c1 = cmd; a1 = addr; d1 = data; end
    else    begin v0 = 1'b1; c0 = cmd; a0 = addr; d0 = data; end
  endtask

  task automatic wait_ready(input bit id, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (id ? rdy1 : rdy0) begin
        if (id) v1 = 1'b0; else v0 = 1'b0;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL ready_timeout: requester %0d got no ready within %0d cycles", id, budget);
    if (id) v1 = 1'b0; else v0 = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL idle_timeout: %0d events outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_enable"}, 64'(en), 64'(0));
    chk({tag, "_ready"}, 64'({rdy1, rdy0}), 64'(0));
    chk({tag, "_done"}, 64'({dn1, dn0}), 64'(0));
    chk({tag, "_err"}, 64'({er1, er0}), 64'(0));
    chk({tag, "_grant"}, 64'(gid), 64'(0));
    chk({tag, "_cmd"}, 64'(scmd), 64'(0));
    chk({tag, "_addr"}, 64'(saddr), 64'(0));
    chk({tag, "_data"}, 64'(sdata), 64'(0));
  endtask

  task automatic both_round(input bit first, input logic [7:0] cf, input logic [23:0] af,
                            input logic [31:0] df, input logic [7:0] cs2,
                            input logic [23:0] as2, input logic [31:0] ds2);
    @(negedge clk);
    push_txn(first, cf, af, df, 1);
    push_txn(!first, cs2, as2, ds2, 1);
    raise(first, cf, af, df);
    raise(!first, cs2, as2, ds2);
    wait_ready(first, 10);
    wait_ready(!first, 200);
    wait_idle(200);
  endtask

  initial begin
    int t0, ten;
    bit got;
    #1 rst = 1'b0;
    #1 check_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // rr=0 at start: 0 wins ties, then alternation 0,1,0,1
    both_round(0, 8'h00, 24'hA0_0001, 32'h1111_0000, 8'h69, 24'hB0_0002, 32'h2222_0000);
    both_round(0, 8'h69, 24'hA0_0003, 32'h3333_0000, 8'h00, 24'hB0_0004, 32'h4444_0000);

    // lone illegal command from req1 while rr points at req0
    push_txn(1, 8'h55, 24'hC0_0005, 32'h5555_0000, 1);
    raise(1, 8'h55, 24'hC0_0005, 32'h5555_0000);
    wait_ready(1, 10);
    wait_idle(20);

    push_txn(0, 8'h69, 24'h00_1234, 32'hDEAD_BEEF, 1);
    raise(0, 8'h69, 24'h00_1234, 32'hDEAD_BEEF);
    wait_ready(0, 10);
    wait_idle(200);

    // rr now points at req1, so req1 wins the tie
    both_round(1, 8'h69, 24'hE0_0007, 32'h7777_0000, 8'h00, 24'hD0_0006, 32'h6666_0000);

    // reset in the middle of WAIT_END drops the transaction silently
    push_txn(0, 8'h00, 24'hF0_0008, 32'h8888_0000, 0);
    raise(0, 8'h00, 24'hF0_0008, 32'h8888_0000);
    wait_ready(0, 10);
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_zero("midreset");
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    push_txn(1, 8'h69, 24'h12_3456, 32'hCAFE_F00D, 1);
    raise(1, 8'h69, 24'h12_3456, 32'hCAFE_F00D);
    wait_ready(1, 10);
    wait_idle(200);

    // timeout instance: cs never falls, abort after 16 cycles
    tc = 8'h00; ta = 24'h00_0BAD; td = 32'h0BAD_0BAD; tv = 1'b1;
    got = 1'b0;
    t0 = 0;
    ten = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (t_rdy0) begin got = 1'b1; t0 = cyc; tv = 1'b0; end
    end
    chk("to_ready_seen", 64'(got), 64'(1));
    tv = 1'b0;
    chk("to_grant", 64'(t_gid), 64'(0));
    chk("to_ready1", 64'(t_rdy1), 64'(0));
    if (t_en) ten++;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (t_dn0) got = 1'b1;
      else if (t_en) ten++;
    end
    chk("to_done_seen", 64'(got), 64'(1));
    chk("to_latency", 64'(cyc - t0), 64'(16));
    chk("to_err", 64'(t_er0), 64'(1));
    chk("to_enable_at_done", 64'(t_en), 64'(0));
    chk("to_enable_cycles", 64'(ten), 64'(15));
    chk("to_busy", 64'(t_busy), 64'(0));
    chk("to_other_done", 64'({t_dn1, t_er1}), 64'(0));
    chk("to_fields", 64'({t_scmd, t_saddr, t_sdata}), {8'h00, 24'h00_0BAD, 32'h0BAD_0BAD});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_req_arbiter.md
SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: max cycles allowed in each of LAUNCH and WAIT_END before abort.
REQ-002 Parameter CMD_READ, default 8'h00: read command code.
REQ-003 Parameter CMD_WRITE, default 8'h69: write command code.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 reqN_valid  in  1  requester N (N=0,1) holds a transaction.
REQ-008 reqN_cmd / reqN_addr / reqN_data  in  8/24/32  command, address, write data of requester N.
REQ-009 reqN_ready  out  1  one-cycle accept pulse to requester N.
REQ-010 reqN_done / reqN_err  out  1/1  one-cycle completion pulse; err qualifies done.
REQ-011 spi_enable  out  1  start request to the SPI master.
REQ-012 spi_commands / spi_address / spi_data_out  out  8/24/32  latched transaction fields to the SPI master.
REQ-013 spi_cs  in  1  SPI master chip select (active low), used for progress detection.
REQ-014 busy / grant_id  out  1/1  transaction in flight; index of the owning requester.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 The FSM SHALL have the states IDLE, LAUNCH, WAIT_END, DONE.
REQ-017 IDLE: if any reqN_valid is sampled at edge t, the winner's fields SHALL be latched; at t+1 reqN_ready=1 for exactly one cycle, busy=1, grant_id=N.
REQ-018 Arbitration SHALL be round-robin: pointer rr selects the winner on simultaneous valid; a lone valid wins regardless of rr.
REQ-019 After each DONE, rr SHALL point to the requester not just served.
REQ-020 A legal cmd (CMD_READ or CMD_WRITE) SHALL move the FSM to LAUNCH with spi_enable=1.
REQ-021 An illegal cmd SHALL go directly to DONE with err=1, and spi_enable SHALL never assert for it.
REQ-022 LAUNCH: spi_enable SHALL hold 1 until spi_cs==0 is sampled, then deassert on the next edge as the FSM enters WAIT_END.
REQ-023 WAIT_END: on spi_cs==1 sampled, the FSM SHALL enter DONE.
REQ-024 spi_commands/spi_address/spi_data_out SHALL stay stable from LAUNCH through WAIT_END, and SHALL hold the last values otherwise.
REQ-025 A 16-bit timeout counter SHALL clear on entry to LAUNCH and WAIT_END and increment each cycle there.
REQ-026 When the counter reaches TIMEOUT_CYCLES-1, the FSM SHALL enter DONE with err=1 and spi_enable=0.
REQ-027 DONE: reqN_done=1 (plus err if flagged) for the granted N for one cycle, busy=0 at the next edge, return to IDLE.
REQ-028 A new grant SHALL be possible on the edge after DONE.
REQ-029 Minimum accept-to-done latency for a legal cmd SHALL be 3 cycles.
REQ-030 Valid activity during LAUNCH/WAIT_END/DONE SHALL be ignored; it is served only once IDLE is re-entered.
REQ-031 A requester SHALL drop reqN_valid within 1 cycle after its ready pulse; a valid still high in IDLE is a new transaction.
REQ-032 Valid withdrawn before ready SHALL cause no action.

Reset
REQ-033 On rst low: state=IDLE, rr=0, counter=0, and all outputs 0 (spi_enable, ready, done, err, busy, grant_id, spi fields).
REQ-034 Reset mid-transaction SHALL drop the transaction with no done pulse.
REQ-035 Reset deassertion SHALL be synchronised externally; the first grant is possible on the second edge after release.

Structure
REQ-036 A package spi_arb_pkg SHALL hold the state encoding, CMD_READ/CMD_WRITE codes and the default TIMEOUT_CYCLES.
REQ-037 The timeout counter SHALL be a sub-module spi_arb_timer (clear, enable, expired).

Verification
REQ-038 Bench: req0 cmd 8'h69, addr 24'h00_1234, data 32'hDEADBEEF; model drops spi_cs 2 cycles after enable and raises it 70 cycles later -> ready0 at t+1, spi fields match, enable falls after cs low, done0=1 and err0=0.
REQ-039 Bench: req0 and req1 both valid with rr=0 -> req0 served first, then req1; repeated both-valid -> grants alternate 0,1,0,1.
REQ-040 Bench: req1 cmd 8'h55 -> ready1 then done1+err1 next cycle, spi_enable stays 0.
REQ-041 Bench: spi_cs held high, TIMEOUT_CYCLES=16 -> done+err exactly 16 cycles after LAUNCH entry, spi_enable=0.
REQ-042 Bench: rst low during WAIT_END -> all outputs 0 asynchronously, no done; after release, req1 valid -> normal grant.
